// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO: any depth >= 3, programmable almost-full/empty
// thresholds, flush, write-through-when-full. Define PFIFO_FWFT_EN for a FWFT read port.
module param_sync_fifo #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_LEVEL   = FIFO_DEPTH - 1,
  parameter int AE_LEVEL   = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic                            wr_en,
  input  logic [FIFO_WIDTH-1:0]           data_in,
  input  logic                            rd_en,
  output logic [FIFO_WIDTH-1:0]           data_out,
  output logic                            rd_valid,
  output logic                            wr_ack,
  output logic                            overflow,
  output logic                            underflow,
  output logic                            full,
  output logic                            empty,
  output logic                            almostfull,
  output logic                            almostempty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] level
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
  localparam logic [PW-1:0] LAST_C  = PW'(FIFO_DEPTH - 1);

  typedef struct packed {
    logic ack;
    logic ovf;
    logic udf;
  } stat_t;

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  stat_t                 stat_q, stat_d;
  logic                  rd_acc, wr_acc;

  assign rd_acc = rd_en && (cnt_q != '0);
  assign wr_acc = wr_en && ((cnt_q < DEPTH_C) || rd_acc);

  // Depth need not be a power of two, so pointers wrap explicitly.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_acc) wr_ptr_d = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + 1'b1;
    if (rd_acc) rd_ptr_d = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + 1'b1;
    if (wr_acc && !rd_acc)      cnt_d = cnt_q + 1'b1;
    else if (rd_acc && !wr_acc) cnt_d = cnt_q - 1'b1;
    stat_d.ack = wr_acc;
    stat_d.ovf = wr_en && !wr_acc;
    stat_d.udf = rd_en && !rd_acc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      stat_q   <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      stat_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      stat_q   <= stat_d;
    end
  end

  // Storage carries no reset; validity is tracked by the count alone.
  always_ff @(posedge clk) begin
    if (!flush && wr_acc) mem[wr_ptr_q] <= data_in;
  end

`ifdef PFIFO_FWFT_EN
  assign data_out = mem[rd_ptr_q];
  assign rd_valid = (cnt_q != '0);
`else
  logic [FIFO_WIDTH-1:0] dout_q;
  logic                  rvld_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q <= '0;
      rvld_q <= 1'b0;
    end else if (flush) begin
      rvld_q <= 1'b0;
    end else begin
      rvld_q <= rd_acc;
      if (rd_acc) dout_q <= mem[rd_ptr_q];
    end
  end

  assign data_out = dout_q;
  assign rd_valid = rvld_q;
`endif

  assign wr_ack      = stat_q.ack;
  assign overflow    = stat_q.ovf;
  assign underflow   = stat_q.udf;
  assign full        = (cnt_q == DEPTH_C);
  assign empty       = (cnt_q == '0);
  assign almostfull  = (cnt_q >= AF_C) && !full;
  assign almostempty = (cnt_q <= AE_C) && !empty;
  assign level       = cnt_q;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Scoreboard bench: stimulus queues expected read words, per-DUT monitors pop on rd_valid.
module tb_param_sync_fifo;

  logic clk, rst;
  int   vec, errs;

  // depth-8 instance (default parameters)
  logic        f8, w8, r8;
  logic [15:0] d8, q8d;
  logic        v8, ack8, ovf8, udf8, full8, emp8, af8, ae8;
  logic [3:0]  lvl8;

  // depth-6 instance for the non-power-of-two wrap
  logic        f6, w6, r6;
  logic [15:0] d6, q6d;
  logic        v6, ack6, ovf6, udf6, full6, emp6, af6, ae6;
  logic [2:0]  lvl6;

  logic [15:0] exp8[$], exp6[$];

  param_sync_fifo u8 (
    .clk(clk), .rst(rst), .flush(f8), .wr_en(w8), .data_in(d8), .rd_en(r8),
    .data_out(q8d), .rd_valid(v8), .wr_ack(ack8), .overflow(ovf8), .underflow(udf8),
    .full(full8), .empty(emp8), .almostfull(af8), .almostempty(ae8), .level(lvl8));

  param_sync_fifo #(.FIFO_WIDTH(16), .FIFO_DEPTH(6), .AF_LEVEL(4), .AE_LEVEL(2)) u6 (
    .clk(clk), .rst(rst), .flush(f6), .wr_en(w6), .data_in(d6), .rd_en(r6),
    .data_out(q6d), .rd_valid(v6), .wr_ack(ack6), .overflow(ovf6), .underflow(udf6),
    .full(full6), .empty(emp6), .almostfull(af6), .almostempty(ae6), .level(lvl6));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitors: sample at the falling edge, away from input changes.
  always @(negedge clk) begin
    if (v8) begin
      if (exp8.size() == 0) chk("u8 unexpected rd_valid", 32'(q8d), 32'hFFFF_FFFF);
      else chk("u8 read data", 32'(q8d), 32'(exp8.pop_front()));
    end
    if (v6) begin
      if (exp6.size() == 0) chk("u6 unexpected rd_valid", 32'(q6d), 32'hFFFF_FFFF);
      else chk("u6 read data", 32'(q6d), 32'(exp6.pop_front()));
    end
  end

  task automatic cyc8(input logic w, input logic [15:0] d, input logic r, input logic f);
    w8 = w; d8 = d; r8 = r; f8 = f;
    @(posedge clk); #1;
  endtask

  task automatic cyc6(input logic w, input logic [15:0] d, input logic r);
    w6 = w; d6 = d; r6 = r;
    @(posedge clk); #1;
  endtask

  initial begin
    int written, lvl, cyc;
    logic [15:0] m6[$];
    logic wa, ra;
    vec = 0; errs = 0;
    rst = 1'b1;
    {f8, w8, r8, f6, w6, r6} = '0;
    d8 = '0; d6 = '0;
    #12;
    chk("reset level", 32'(lvl8), 0);
    chk("reset empty/full/af/ae", {28'd0, emp8, full8, af8, ae8}, 32'b1000);
    chk("reset pulses/valid", {28'd0, v8, ack8, ovf8, udf8}, 0);
    chk("reset data_out", 32'(q8d), 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // fill 1..8
    for (int i = 1; i <= 8; i++) begin
      cyc8(1, 16'(i), 0, 0);
      chk("fill wr_ack", 32'(ack8), 1);
      chk("fill level", 32'(lvl8), 32'(i));
      chk("fill almostfull", 32'(af8), 32'(i == 7));
      chk("fill almostempty", 32'(ae8), 32'(i == 1));
      chk("fill full", 32'(full8), 32'(i == 8));
    end
    cyc8(1, 16'h0099, 0, 0);
    chk("overflow pulse", 32'(ovf8), 1);
    chk("overflow no ack", 32'(ack8), 0);
    chk("overflow level", 32'(lvl8), 8);
    cyc8(0, 0, 0, 0);
    chk("overflow one cycle", 32'(ovf8), 0);

    // write-through while full
    exp8.push_back(16'h0001);
    cyc8(1, 16'h0009, 1, 0);
    chk("full rw ack", 32'(ack8), 1);
    chk("full rw no ovf", 32'(ovf8), 0);
    chk("full rw level", 32'(lvl8), 8);

    // drain 2..9
    for (int i = 2; i <= 9; i++) begin
      exp8.push_back(16'(i));
      cyc8(0, 0, 1, 0);
      chk("drain level", 32'(lvl8), 32'(9 - i));
      chk("drain almostempty", 32'(ae8), 32'(i == 8));
      chk("drain almostfull", 32'(af8), 32'(i == 2));
    end
    chk("drained empty", 32'(emp8), 1);

    cyc8(0, 0, 1, 0);
    chk("underflow pulse", 32'(udf8), 1);
    chk("underflow data holds", 32'(q8d), 32'h9);
    chk("underflow no valid", 32'(v8), 0);
    cyc8(0, 0, 0, 0);
    chk("underflow one cycle", 32'(udf8), 0);

    // empty with both: write wins, read rejected
    cyc8(1, 16'h000A, 1, 0);
    chk("empty rw ack", 32'(ack8), 1);
    chk("empty rw underflow", 32'(udf8), 1);
    chk("empty rw level", 32'(lvl8), 1);

    // flush at level 5 with wr_en and rd_en
    for (int i = 11; i <= 14; i++) cyc8(1, 16'(i), 0, 0);
    chk("pre-flush level", 32'(lvl8), 5);
    cyc8(1, 16'h0055, 1, 1);
    chk("flush level", 32'(lvl8), 0);
    chk("flush empty", 32'(emp8), 1);
    chk("flush pulses/valid", {28'd0, v8, ack8, ovf8, udf8}, 0);
    cyc8(1, 16'hBEEF, 0, 0);
    exp8.push_back(16'hBEEF);
    cyc8(0, 0, 1, 0);
    chk("post-flush level", 32'(lvl8), 0);
    cyc8(0, 0, 0, 0);

    // async reset mid-stream at level 3
    for (int i = 1; i <= 4; i++) cyc8(1, 16'(i), 0, 0);
    exp8.push_back(16'h0001);
    cyc8(0, 0, 1, 0);
    chk("pre-reset level", 32'(lvl8), 3);
    #5;
    cyc6(0, 0, 0);
    w8 = 0; r8 = 0;
    #2;
    rst = 1'b1;
    #1;
    chk("async reset level", 32'(lvl8), 0);
    chk("async reset flags", {28'd0, emp8, full8, af8, ae8}, 32'b1000);
    chk("async reset pulses/valid", {28'd0, v8, ack8, ovf8, udf8}, 0);
    chk("async reset data_out", 32'(q8d), 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // depth-6 stream of 20 words, interleaved reads, bench-side occupancy model
    written = 0; lvl = 0; cyc = 0;
    while ((written < 20 || lvl != 0) && cyc < 300) begin
      w6 = (written < 20) && (cyc % 3 != 2);
      r6 = (cyc >= 3 && cyc % 2 == 0) || (written == 20);
      d6 = 16'(16'h0100 + written);
      ra = r6 && (lvl != 0);
      wa = w6 && (lvl < 6 || ra);
      if (ra) exp6.push_back(m6.pop_front());
      if (wa) begin m6.push_back(d6); written++; end
      lvl = lvl + int'(wa) - int'(ra);
      @(posedge clk); #1;
      chk("u6 level", 32'(lvl6), 32'(lvl));
      chk("u6 almostfull", 32'(af6), 32'(lvl >= 4 && lvl <= 5));
      chk("u6 almostempty", 32'(ae6), 32'(lvl >= 1 && lvl <= 2));
      chk("u6 overflow", 32'(ovf6), 32'(w6 && !wa));
      cyc++;
    end
    chk("u6 stream completed", 32'(written == 20 && lvl == 0), 1);
    cyc6(0, 0, 0);
    @(negedge clk); #1;
    chk("u8 scoreboard drained", 32'(exp8.size()), 0);
    chk("u6 scoreboard drained", 32'(exp6.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/param_sync_fifo.md
# param_sync_fifo

Parametrised single-clock FIFO and the next generation of the team's 16x8 synchronous FIFO. It adds configurable width, depth (not limited to powers of two), programmable almost-full and almost-empty thresholds, an occupancy output, a synchronous flush, and read/write-through when full. An optional first-word-fall-through read port is selected at compile time. It sits between producer and consumer logic in the same clock domain.

## Interface
- FIFO_WIDTH, 16, data word width in bits (>=1).
- FIFO_DEPTH, 8, number of entries (>=3, any integer).
- AF_LEVEL, FIFO_DEPTH-1, almostfull threshold; requires AE_LEVEL < AF_LEVEL <= FIFO_DEPTH-1.
- AE_LEVEL, 1, almostempty threshold; requires 1 <= AE_LEVEL.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of contents.
- wr_en  in  1  write request.
- data_in  in  FIFO_WIDTH  write data.
- rd_en  in  1  read request.
- data_out  out  FIFO_WIDTH  read data.
- rd_valid  out  1  data_out holds a valid popped or head word.
- wr_ack  out  1  registered pulse: the previous-cycle write was accepted.
- overflow  out  1  registered pulse: the previous-cycle write was rejected.
- underflow  out  1  registered pulse: the previous-cycle read was rejected.
- full, empty, almostfull, almostempty  out  1 each  occupancy flags.
- level  out  $clog2(FIFO_DEPTH+1)  current entry count.

## Operation
- Reset (rst=1, asynchronous): pointers, count, data_out, rd_valid, wr_ack, overflow and underflow go to 0. empty=1; full, almostfull and almostempty are 0.
- Precedence at each edge: rst, then flush, then normal operation.
- flush=1: pointers and count go to 0. wr_en and rd_en are ignored that cycle. wr_ack, overflow, underflow and rd_valid go to 0. data_out holds its value.
- Read accepted: rd_en && count!=0.
- Write accepted: wr_en && (count<FIFO_DEPTH || read accepted). A write while full succeeds when a read is accepted in the same cycle.
- Count update: +1 on write only, -1 on read only, unchanged on both or neither. count never exceeds FIFO_DEPTH and never underflows.
- Empty with wr_en and rd_en together: the write is accepted, the read is rejected (underflow=1 next cycle), and count goes to 1.
- Pointers: each increments on its accepted operation and wraps explicitly from FIFO_DEPTH-1 to 0. Pointer arithmetic is never a natural power-of-two roll-over.
- Flags are combinational from count:
  - full = count==FIFO_DEPTH.
  - empty = count==0.
  - almostfull = count>=AF_LEVEL && !full.
  - almostempty = count<=AE_LEVEL && !empty.
  - level = count.
- wr_ack is 1 for exactly one cycle per accepted write. overflow is 1 one cycle after each rejected wr_en. underflow is 1 one cycle after each rejected rd_en.

## Timing
- Write to visibility: a word written at edge N counts toward level and flags after edge N.
- Standard read (macro absent): on an accepted read at edge N, data_out = the head word after edge N and rd_valid=1 for that cycle only. Otherwise rd_valid=0 and data_out holds.
- Back-to-back reads deliver one word per cycle.
- Status pulses (wr_ack, overflow, underflow) have 1-cycle latency and never stretch.
- Reset asserted mid-operation: outputs take their reset values immediately, without waiting for clk. Deassertion is synchronised to clk by the system.

## Configuration
- PFIFO_FWFT_EN defined: first-word-fall-through read port.
  - data_out = mem[rd_ptr] combinationally and rd_valid = !empty.
  - rd_en acknowledges (pops) the displayed word; the next word appears after the edge.
  - A word written into an empty FIFO at edge N is on data_out after edge N.
  - Reset and flush force rd_valid=0.
- PFIFO_FWFT_EN undefined: standard registered read as described under Timing.

## Test plan
- Reset/fill/drain, FIFO_DEPTH=8: write 0x0001..0x0008 on 8 cycles, then read 8.
  - wr_ack pulses 8 times; full=1 with level=8.
  - almostfull=1 only at level 7; almostempty=1 only at level 1.
  - Reads return 0x0001..0x0008 in order; empty=1 at the end.
- Overflow/underflow: write while level=8 -> overflow=1 for one cycle, level stays 8. Read while empty -> underflow=1 for one cycle, data_out unchanged.
- Simultaneous operations:
  - Full with wr_en and rd_en -> both accepted, level stays 8, no overflow.
  - Empty with both -> write accepted, underflow=1, level=1.
- Non-power-of-two wrap, FIFO_DEPTH=6, AF_LEVEL=4, AE_LEVEL=2: stream 20 words with interleaved reads.
  - Data order is preserved across the 5 -> 0 pointer wrap.
  - almostfull is 1 at level 4..5; almostempty is 1 at level 1..2.
- Flush: at level 5, assert flush together with wr_en and rd_en -> level=0, empty=1, no wr_ack, overflow or underflow next cycle. The next write of 0xBEEF reads back as 0xBEEF.
- Async reset mid-stream at level 3 -> all outputs take their reset values before the next clk edge. PFIFO_FWFT_EN build: data_out shows 0x0001 one cycle after the first write, with no rd_en asserted.
